// File: rtl/counter_load_sched.sv
// Reload scheduler for a loadable counter: queues reload values and issues a one-cycle load pulse at terminal count.
// Optional COUNTER_LOAD_SCHED_BYPASS_EN forwards in_data straight to the counter on an empty trigger.
module counter_load_sched #(
  parameter int unsigned     WIDTH = 4,
  parameter int unsigned     DEPTH = 4,
  parameter logic [WIDTH-1:0] TERM = 4'hF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [WIDTH-1:0]           count_in,
  output logic                       load,
  output logic [WIDTH-1:0]           load_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [7:0]                 reload_count,
  output logic                       underrun
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic trigger;
  logic fifo_empty;
  logic push;
  logic push_store;
  logic pop;
  logic bypass;
  logic starve;
  logic issue;

  // Ready depends only on the registered level and reset, never on in_valid or count_in.
  assign in_ready   = (fifo_level < LW'(DEPTH)) && !reset;
  assign fifo_empty = (fifo_level == '0);
  assign trigger    = (count_in == TERM) && !load;
  assign push       = in_valid && in_ready;
  assign pop        = trigger && !fifo_empty;

`ifdef COUNTER_LOAD_SCHED_BYPASS_EN
  assign bypass = trigger && fifo_empty && in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed value completes its handshake but is never written to storage.
  assign push_store = push && !bypass;
  assign starve     = trigger && fifo_empty && !bypass;
  assign issue      = pop || bypass;

  // Storage carries no reset; validity is tracked by the level and pointers.
  always_ff @(posedge clk) begin
    if (push_store) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, level, load pulse and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      load         <= 1'b0;
      load_data    <= '0;
      reload_count <= '0;
      underrun     <= 1'b0;
    end else begin
      if (push_store) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_level <= fifo_level + LW'(push_store) - LW'(pop);
      load       <= issue;
      if (pop) begin
        load_data <= mem[rd_ptr];
      end else if (bypass) begin
        load_data <= in_data;
      end
      if (issue && (reload_count != 8'hFF)) begin
        reload_count <= reload_count + 8'd1;
      end
      if (starve) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_load_sched.sv
// Directed self-checking bench for counter_load_sched.
module tb_counter_load_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] count_in;
  logic       load;
  logic [3:0] load_data;
  logic [2:0] fifo_level;
  logic [7:0] reload_count;
  logic       underrun;

  int errors = 0;
  int checks = 0;
  int rc_exp = 0;

  counter_load_sched #(.WIDTH(4), .DEPTH(4), .TERM(4'hF)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .count_in     (count_in),
    .load         (load),
    .load_data    (load_data),
    .fifo_level   (fifo_level),
    .reload_count (reload_count),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; count_in = '0;

    // Reset values
    tick(); tick();
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_load_data", 32'(load_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_reload_count", 32'(reload_count), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_level", 32'(fifo_level), 32'd0);

    // Normal reload: 3 then 7
    in_valid = 1'b1; in_data = 4'h3; tick();
    in_data = 4'h7; tick();
    in_valid = 1'b0;
    chk("norm_level2", 32'(fifo_level), 32'd2);
    count_in = 4'hF; tick();
    chk("norm_load1", 32'(load), 32'd1);
    chk("norm_data1", 32'(load_data), 32'h3);
    chk("norm_level1", 32'(fifo_level), 32'd1);
    count_in = 4'h0; tick();
    chk("norm_idle_load", 32'(load), 32'd0);
    chk("norm_idle_hold", 32'(load_data), 32'h3);
    count_in = 4'hF; tick();
    chk("norm_load2", 32'(load), 32'd1);
    chk("norm_data2", 32'(load_data), 32'h7);
    count_in = 4'h0; tick();
    rc_exp = 2;
    chk("norm_reload_count", 32'(reload_count), 32'(rc_exp));
    chk("norm_level0", 32'(fifo_level), 32'd0);
    chk("norm_underrun", 32'(underrun), 32'd0);

    // Full FIFO: offer A..E, only A..D fit
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'(4'hA + i);
      tick();
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    count_in = 4'hF; #1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_pop_load", 32'(load), 32'd1);
    chk("full_pop_data", 32'(load_data), 32'hA);
    chk("full_pop_level", 32'(fifo_level), 32'd3);
    chk("full_ready_again", 32'(in_ready), 32'd1);
    in_valid = 1'b0; count_in = 4'h0; tick();
    for (int i = 1; i < 4; i++) begin
      count_in = 4'hF; tick();
      chk("drain_data", 32'(load_data), 32'(4'hA + i));
      count_in = 4'h0; tick();
    end
    rc_exp = 6;
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_reload_count", 32'(reload_count), 32'(rc_exp));

`ifdef COUNTER_LOAD_SCHED_BYPASS_EN
    // Bypass: empty trigger with a value offered
    in_valid = 1'b1; in_data = 4'h5; count_in = 4'hF; #1;
    chk("byp_in_ready", 32'(in_ready), 32'd1);
    tick();
    rc_exp++;
    chk("byp_load", 32'(load), 32'd1);
    chk("byp_data", 32'(load_data), 32'h5);
    chk("byp_underrun", 32'(underrun), 32'd0);
    chk("byp_level", 32'(fifo_level), 32'd0);
    chk("byp_reload_count", 32'(reload_count), 32'(rc_exp));
    in_valid = 1'b0; count_in = 4'h0; tick();
`endif

    // Underrun: empty trigger with nothing offered
    count_in = 4'hF; tick();
    chk("und_load", 32'(load), 32'd0);
    chk("und_flag", 32'(underrun), 32'd1);
    chk("und_reload_count", 32'(reload_count), 32'(rc_exp));
    count_in = 4'h0; tick(); tick();
    chk("und_sticky", 32'(underrun), 32'd1);

    // Back-to-back: loaded TERM retriggers, but never while load is high
    in_valid = 1'b1; in_data = 4'hF; tick();
    in_data = 4'h2; tick();
    in_valid = 1'b0; count_in = 4'hF;
    tick();
    chk("b2b_n1_load", 32'(load), 32'd1);
    chk("b2b_n1_data", 32'(load_data), 32'hF);
    tick();
    chk("b2b_n2_load", 32'(load), 32'd0);
    chk("b2b_n2_level", 32'(fifo_level), 32'd1);
    tick();
    chk("b2b_n3_load", 32'(load), 32'd1);
    chk("b2b_n3_data", 32'(load_data), 32'h2);
    count_in = 4'h0; tick();
    rc_exp += 2;
    chk("b2b_reload_count", 32'(reload_count), 32'(rc_exp));
    chk("b2b_level", 32'(fifo_level), 32'd0);

    // Reset mid-operation with 3 queued and a trigger plus push pending
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 4'(i);
      tick();
    end
    chk("mid_level3", 32'(fifo_level), 32'd3);
    in_data = 4'h9; count_in = 4'hF; reset = 1'b1; #1;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("mid_load", 32'(load), 32'd0);
    chk("mid_level", 32'(fifo_level), 32'd0);
    chk("mid_reload_count", 32'(reload_count), 32'd0);
    chk("mid_underrun", 32'(underrun), 32'd0);
    reset = 1'b0; in_valid = 1'b0; count_in = 4'h0; tick();
    chk("mid_after_level", 32'(fifo_level), 32'd0);
    chk("mid_after_load", 32'(load), 32'd0);

    // Saturation of reload_count
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1; in_data = 4'(i); count_in = 4'h0; tick();
      in_valid = 1'b0; count_in = 4'hF; tick();
      if (i == 254) chk("sat_at_ff", 32'(reload_count), 32'hFF);
      count_in = 4'h0; tick();
    end
    chk("sat_hold", 32'(reload_count), 32'hFF);
    chk("sat_level", 32'(fifo_level), 32'd0);
    chk("sat_underrun", 32'(underrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_load_sched.md
# counter_load_sched

Load scheduler that sits directly upstream of the 4-bit loadable counter and drives its `load` / `load_data` inputs. Software or a sequencer pushes reload values through a valid/ready port into a small FIFO. Each time the counter output reaches the terminal value, the scheduler pops the oldest value and issues a one-cycle registered load pulse, so the counter restarts from a queued value instead of wrapping. The block also reports FIFO level, a reload count and a sticky underrun flag.

## Interface
- `WIDTH`, 4: width of count and load values.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TERM`, 4'hF: terminal count value that triggers a reload.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: a reload value is offered.
- `in_ready` output 1: the FIFO accepts the value this cycle.
- `in_data` input WIDTH: reload value.
- `count_in` input WIDTH: current counter output (`count`).
- `load` output 1: registered load pulse to the counter.
- `load_data` output WIDTH: registered value to the counter; valid when `load`=1.
- `fifo_level` output $clog2(DEPTH+1): number of stored entries.
- `reload_count` output 8: number of loads issued, saturating at 8'hFF.
- `underrun` output 1: sticky; set when a trigger finds no value available.

## Operation
- **Push:** occurs when `in_valid && in_ready`. `in_ready` = (`fifo_level` < `DEPTH`) && !`reset`. `in_ready` is not raised by a same-cycle pop; a full FIFO never accepts.
- **Trigger:** `count_in == TERM` && !`load`. Gating with `load` prevents a second pop while a load is in flight.
- **Pop:** trigger && `fifo_level` > 0. The head entry is removed and registered into `load_data`, and `load` is set for exactly one cycle. `reload_count` increments, saturating at 8'hFF.
- **Empty trigger:** trigger && `fifo_level` == 0 (and no bypass; see Configuration).
  - No load is issued, so the counter wraps naturally.
  - `underrun` is set and stays set until `reset`.
- **Push and pop in the same cycle:** both happen, and `fifo_level` is unchanged. FIFO order is strict first-in, first-out.
- **Pointers:** read and write pointers wrap modulo `DEPTH`. Level arithmetic is exact; there is no overflow because pushes are blocked at full.
- **`load_data` when idle:** holds its last value while `load`=0.
- **Reset:** `load`=0, `load_data`=0, `fifo_level`=0, pointers=0, `reload_count`=0, `underrun`=0.
  - Asserting `reset` mid-operation discards all queued entries and any pending load on the next edge.
  - A push offered in a reset cycle is dropped (`in_ready`=0).

## Timing
- **Trigger to load:** `count_in`==`TERM` in cycle N → `load`=1 in cycle N+1 → the counter holds `load_data` after edge N+2.
- During cycle N+1 the counter has wrapped to 0. This is expected and does not retrigger.
- **Retrigger:** if the loaded value equals `TERM`, the next trigger occurs in cycle N+2 and a further pop follows. This is legal.
- **Push latency:** a value pushed at edge E is visible in `fifo_level` after E. It can be popped by a trigger in the cycle after E.
- **`in_ready` timing:** combinational from registered `fifo_level` and `reset` only. There is no combinational path from `in_valid` or `count_in` to `in_ready`.

## Configuration
- `COUNTER_LOAD_SCHED_BYPASS_EN` defined: on an empty trigger with `in_valid`=1, `in_data` is forwarded directly.
  - The next cycle has `load`=1 and `load_data`=`in_data`.
  - The handshake completes (`in_ready`=1) without storing the value.
  - `underrun` is not set and `reload_count` increments.
- Macro undefined: no bypass path exists, and an empty trigger always sets `underrun` as described above.

## Test plan
- **Reset values:** hold `reset` 2 cycles → all outputs 0 and `in_ready`=0; first cycle after release, `in_ready`=1 and `fifo_level`=0.
- **Normal reload:** push 4'h3, 4'h7; drive `count_in` 4'hF in cycle N → `load`=1 with `load_data`=4'h3 in N+1. Next `TERM` → `load_data`=4'h7. `reload_count`=2 and `fifo_level`=0.
- **Full FIFO:** push 5 values with `in_valid` held high → only 4 accepted. `in_ready`=0 at `fifo_level`=4. A simultaneous trigger pops one entry, but `in_ready` is still 0 in that cycle.
- **Underrun:** with an empty FIFO, `count_in`=4'hF → no `load`, `underrun`=1 sticky, `reload_count` unchanged. With the bypass macro and `in_valid`=1, `in_data`=4'h5 → `load`=1, `load_data`=4'h5, `underrun`=0.
- **Back-to-back and no double-pop:** push 4'hF then 4'h2. Hold `count_in`=4'hF for 3 cycles. Expect loads 4'hF in N+1 and 4'h2 in N+3; no load in N+2.
- **Reset mid-operation:** with 3 entries queued, assert `reset` in the trigger cycle → no `load` next cycle, `fifo_level`=0, `reload_count`=0.
